// File: rtl/adder_share_arbiter.sv
// Round-robin front end that time-shares one 32-bit adder between NUM_REQ requesters.
// Each accepted request makes one IDLE -> EXEC -> RESP pass and produces one registered response.
module adder_share_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NUM_REQ-1:0]    req_valid,
   output logic [NUM_REQ-1:0]    req_ready,
   input  logic [NUM_REQ*32-1:0] req_a,
   input  logic [NUM_REQ*32-1:0] req_b,
   input  logic [NUM_REQ-1:0]    req_cin,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [ID_W-1:0]       rsp_id,
   output logic [31:0]           rsp_sum,
   output logic                  rsp_cout,
   output logic                  rsp_of
);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

   state_e          state_q;
   logic [ID_W-1:0] rr_ptr_q;
   logic [ID_W-1:0] id_q;
   logic [31:0]     a_q;
   logic [31:0]     b_q;
   logic            cin_q;
   logic            rsp_valid_q;
   logic [ID_W-1:0] rsp_id_q;
   logic [31:0]     rsp_sum_q;
   logic            rsp_cout_q;
   logic            rsp_of_q;

   logic            grant_vld_d;
   logic [ID_W-1:0] grant_id_d;
   logic [ID_W-1:0] rr_ptr_d;
   logic [32:0]     add_full;
   logic            add_of;

   // Offsets are walked from the farthest to the nearest so the last hit is the
   // first valid requester at or after rr_ptr in circular order.
   always_comb begin
      int idx;
      // NOTE: every always_comb output gets a default first so no path infers a latch.
      grant_vld_d = 1'b0;
      grant_id_d  = '0;
      idx         = 0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         idx = int'(rr_ptr_q) + k;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         if (req_valid[idx]) begin
            grant_vld_d = 1'b1;
            grant_id_d  = ID_W'(idx);
         end
      end
   end

   always_comb begin
      req_ready = '0;
      if (state_q == IDLE && grant_vld_d) req_ready[grant_id_d] = 1'b1;
   end

   // Shared adder plus the signed-overflow detector, fed only by latched operands.
   assign add_full = {1'b0, a_q} + {1'b0, b_q} + {32'd0, cin_q};
   assign add_of   = (a_q[31] == b_q[31]) && (add_full[31] != a_q[31]);

   assign rr_ptr_d = (id_q == ID_W'(NUM_REQ - 1)) ? '0 : id_q + ID_W'(1);

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         rr_ptr_q    <= '0;
         id_q        <= '0;
         a_q         <= '0;
         b_q         <= '0;
         cin_q       <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= '0;
         rsp_sum_q   <= '0;
         rsp_cout_q  <= 1'b0;
         rsp_of_q    <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (grant_vld_d) begin
                  a_q     <= req_a[32*int'(grant_id_d) +: 32];
                  b_q     <= req_b[32*int'(grant_id_d) +: 32];
                  cin_q   <= req_cin[grant_id_d];
                  id_q    <= grant_id_d;
                  state_q <= EXEC;
               end
            end
            EXEC: begin
               rsp_sum_q   <= add_full[31:0];
               rsp_cout_q  <= add_full[32];
               rsp_of_q    <= add_of;
               rsp_id_q    <= id_q;
               rsp_valid_q <= 1'b1;
               state_q     <= RESP;
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  rr_ptr_q    <= rr_ptr_d;
                  state_q     <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_id    = rsp_id_q;
   assign rsp_sum   = rsp_sum_q;
   assign rsp_cout  = rsp_cout_q;
   assign rsp_of    = rsp_of_q;

endmodule

// File: doc/adder_share_arbiter.md
# adder_share_arbiter

Round-robin arbiter and sequencer that shares one 32-bit ripple adder (NormalAdder plus the overflow detector) between NUM_REQ requesters. It accepts one add request at a time over a valid/ready handshake, latches operands, runs them through the shared adder, and returns sum, carry-out, signed-overflow and requester ID over a registered valid/ready response port. It sits between the requesting datapath blocks and the single adder instance, so no requester drives the adder directly.

## Interface
Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- ID_W, 2, width of requester ID; must equal clog2(NUM_REQ)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  NUM_REQ  request valid, one bit per requester
- req_ready  out  NUM_REQ  one-hot grant/accept pulse
- req_a  in  NUM_REQ*32  operand A, requester i at bits [32*i+31:32*i]
- req_b  in  NUM_REQ*32  operand B, same packing
- req_cin  in  NUM_REQ  carry-in per requester
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumer ready
- rsp_id  out  ID_W  index of the requester that was served
- rsp_sum  out  32  A + B + cin, modulo 2^32
- rsp_cout  out  1  carry out of bit 31
- rsp_of  out  1  signed overflow: (A[31]==B[31]) && (sum[31]!=A[31])

## Operation
- FSM states: IDLE, EXEC, RESP. Reset state IDLE.
- IDLE: if any req_valid set, grant the first set bit searching upward from rr_ptr with wrap (rr_ptr, rr_ptr+1, …, NUM_REQ-1, 0, …). req_ready[grant] = 1 combinationally in this cycle only; all other req_ready bits 0. On the clock edge, latch A, B, cin, grant ID; go to EXEC. No req_valid: stay IDLE, req_ready = 0.
- EXEC: latched operands drive the shared adder; at clock edge register sum, cout, of into rsp_*; set rsp_valid; go to RESP.
- RESP: hold rsp_* stable while rsp_valid=1 and rsp_ready=0. On rsp_valid & rsp_ready: clear rsp_valid, rr_ptr <= (granted ID + 1) mod NUM_REQ, go to IDLE.
- req_ready is 0 in EXEC and RESP; requests arriving then wait (requesters hold valid and operands until ready).
- Arithmetic: unsigned 32-bit add with cin; rsp_of computed from latched A[31], B[31] and sum[31] per the overflow definition; cout and of are independent (e.g. -1 + -2^31 gives cout=1, of=1).
- Fairness: a requester holding valid is served within NUM_REQ grants.
- Reset mid-operation (EXEC or RESP): in-flight transaction discarded, no response emitted.

## Timing
- Reset values: req_ready=0, rsp_valid=0, rsp_id=0, rsp_sum=0, rsp_cout=0, rsp_of=0, rr_ptr=0, state IDLE.
- Accept at cycle t (IDLE, req_valid & req_ready) -> rsp_valid high from cycle t+2.
- Response consumed at cycle u (rsp_valid & rsp_ready) -> earliest next accept at cycle u+1. Back-to-back throughput: one result per 3 cycles with rsp_ready held high.
- rsp_ready high before rsp_valid has no effect.
- req_valid dropped by requester before grant: no grant to it; not an error.
- rsp_* outputs are registered; req_ready is combinational from state, req_valid and rr_ptr only (no path from rsp_ready).

## Test plan
- Single requester 0: A=0x7FFFFFFF, B=0x00000001, cin=0 -> req_ready[0] at t, rsp_valid at t+2 with sum=0x80000000, cout=0, of=1, id=0.
- Requester 2: A=0xFFFFFFFF, B=0x80000000, cin=0 -> sum=0x7FFFFFFF, cout=1, of=1, id=2; then A=0xFFFFFFFF, B=0xFFFFFFFF, cin=1 -> sum=0xFFFFFFFF, cout=1, of=0.
- All four requesters valid continuously, rsp_ready=1: grants in order 0,1,2,3,0; rsp_id follows same order; one response every 3 cycles.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid -> rsp_* stable, req_ready stays 0 despite pending req_valid; release -> next grant next cycle.
- Round-robin pointer: serve requester 3, then requesters 0 and 3 both valid -> requester 0 granted first.
- Reset asserted in EXEC -> next cycle all outputs at reset values, no rsp_valid; a held request is re-granted from rr_ptr=0 afterwards.
